// File: rtl/jelly_axi4_dma_reader_sequencer.sv
// Line/frame sequencer for the AXI4 DMA reader: issues one reader command per frame line.
// Optional `JELLY_AXI4_DMA_READER_SEQUENCER_BANK_EN alternates frames between two base addresses.
module jelly_axi4_dma_reader_sequencer #(
  parameter int unsigned ADDR_WIDTH          = 32,
  parameter int unsigned COUNT_WIDTH         = 30,
  parameter int unsigned HEIGHT_WIDTH        = 12,
  parameter int unsigned FRAME_COUNTER_WIDTH = 16
) (
  input  logic                           aclk,
  input  logic                           aresetn,

  input  logic                           ctl_enable,
  input  logic                           ctl_oneshot,
  output logic                           ctl_busy,
  output logic                           ctl_frame_done,

  output logic [HEIGHT_WIDTH-1:0]        status_line,
  output logic [FRAME_COUNTER_WIDTH-1:0] status_frame_count,
  output logic                           status_bank,

  input  logic [ADDR_WIDTH-1:0]          param_addr,
  input  logic [ADDR_WIDTH-1:0]          param_bank_addr,
  input  logic [ADDR_WIDTH-1:0]          param_stride,
  input  logic [COUNT_WIDTH-1:0]         param_width,
  input  logic [HEIGHT_WIDTH-1:0]        param_height,

  output logic                           dma_enable,
  input  logic                           dma_busy,
  output logic [ADDR_WIDTH-1:0]          dma_addr,
  output logic [COUNT_WIDTH-1:0]         dma_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_NEXT
  } state_t;

  state_t                         state_q, state_d;
  logic [ADDR_WIDTH-1:0]          stride_q, stride_d;
  logic [HEIGHT_WIDTH-1:0]        height_q, height_d;
  logic [HEIGHT_WIDTH-1:0]        line_q, line_d;
  logic [FRAME_COUNTER_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
  logic [COUNT_WIDTH-1:0]         count_q, count_d;
  logic                           last_q, last_d;
  logic                           dma_en_q, dma_en_d;
  logic                           done_q, done_d;
  logic                           busy_q, busy_d;
  logic                           bank_q;
  logic [ADDR_WIDTH-1:0]          base_c;
  logic                           start_c;
  logic                           finish_c;

`ifdef JELLY_AXI4_DMA_READER_SEQUENCER_BANK_EN
  logic bank_d;
  assign base_c = bank_q ? param_bank_addr : param_addr;
`else
  logic unused_bank_addr;
  assign unused_bank_addr = ^param_bank_addr;
  assign bank_q           = 1'b0;
  assign base_c           = param_addr;
`endif

  // Next-state and next-output logic; frame start and frame completion are shared by several states.
  always_comb begin
    state_d     = state_q;
    stride_d    = stride_q;
    height_d    = height_q;
    line_d      = line_q;
    frame_cnt_d = frame_cnt_q;
    addr_d      = addr_q;
    count_d     = count_q;
    last_d      = 1'b0;
    dma_en_d    = 1'b0;
    done_d      = 1'b0;
    start_c     = 1'b0;
    finish_c    = 1'b0;
`ifdef JELLY_AXI4_DMA_READER_SEQUENCER_BANK_EN
    bank_d      = bank_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (ctl_enable && !dma_busy) begin
          start_c = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (dma_busy) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!dma_busy) begin
          state_d  = ST_NEXT;
          finish_c = (line_q == height_q - HEIGHT_WIDTH'(1));
        end
      end
      ST_NEXT: begin
        if (last_q) begin
          if (ctl_enable && !ctl_oneshot) begin
            start_c = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          addr_d   = addr_q + stride_q;
          line_d   = line_q + HEIGHT_WIDTH'(1);
          dma_en_d = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Frame start: shadow the geometry; an empty frame skips straight to completion.
    if (start_c) begin
      stride_d = param_stride;
      height_d = param_height;
      line_d   = '0;
      addr_d   = base_c;
      count_d  = param_width;
      if (param_width == '0 || param_height == '0) begin
        state_d  = ST_NEXT;
        finish_c = 1'b1;
      end else begin
        state_d  = ST_ISSUE;
        dma_en_d = 1'b1;
      end
    end

    if (finish_c) begin
      last_d      = 1'b1;
      done_d      = 1'b1;
      frame_cnt_d = frame_cnt_q + FRAME_COUNTER_WIDTH'(1);
`ifdef JELLY_AXI4_DMA_READER_SEQUENCER_BANK_EN
      bank_d      = ~bank_q;
`endif
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      stride_q    <= '0;
      height_q    <= '0;
      line_q      <= '0;
      frame_cnt_q <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      last_q      <= 1'b0;
      dma_en_q    <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stride_q    <= stride_d;
      height_q    <= height_d;
      line_q      <= line_d;
      frame_cnt_q <= frame_cnt_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      last_q      <= last_d;
      dma_en_q    <= dma_en_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

`ifdef JELLY_AXI4_DMA_READER_SEQUENCER_BANK_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bank_q <= 1'b0;
    end else begin
      bank_q <= bank_d;
    end
  end
`endif

  assign ctl_busy           = busy_q;
  assign ctl_frame_done     = done_q;
  assign status_line        = line_q;
  assign status_frame_count = frame_cnt_q;
  assign status_bank        = bank_q;
  assign dma_enable         = dma_en_q;
  assign dma_addr           = addr_q;
  assign dma_count          = count_q;

endmodule

// File: tb/tb_jelly_axi4_dma_reader_sequencer.sv
// Directed bench for jelly_axi4_dma_reader_sequencer with a simple reader busy model.
module tb_jelly_axi4_dma_reader_sequencer;

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 30;
  localparam int unsigned HW = 12;
  localparam int unsigned FW = 16;
`ifdef JELLY_AXI4_DMA_READER_SEQUENCER_BANK_EN
  localparam bit BANK = 1'b1;
`else
  localparam bit BANK = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          ctl_enable = 1'b0;
  logic          ctl_oneshot = 1'b0;
  logic          ctl_busy;
  logic          ctl_frame_done;
  logic [HW-1:0] status_line;
  logic [FW-1:0] status_frame_count;
  logic          status_bank;
  logic [AW-1:0] param_addr = '0;
  logic [AW-1:0] param_bank_addr = '0;
  logic [AW-1:0] param_stride = '0;
  logic [CW-1:0] param_width = '0;
  logic [HW-1:0] param_height = '0;
  logic          dma_enable;
  logic          dma_busy = 1'b0;
  logic [AW-1:0] dma_addr;
  logic [CW-1:0] dma_count;

  int total = 0;
  int bad   = 0;

  // reader model state
  int            n_issue = 0;
  int            n_done  = 0;
  int            dbl     = 0;
  int            remain  = 0;
  int            hold    = 20;
  logic          prev_en = 1'b0;
  logic          ext_busy = 1'b0;
  logic [AW-1:0] log_addr  [0:255];
  logic [CW-1:0] log_count [0:255];

  jelly_axi4_dma_reader_sequencer #(
    .ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .HEIGHT_WIDTH(HW), .FRAME_COUNTER_WIDTH(FW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .ctl_enable(ctl_enable), .ctl_oneshot(ctl_oneshot),
    .ctl_busy(ctl_busy), .ctl_frame_done(ctl_frame_done),
    .status_line(status_line), .status_frame_count(status_frame_count), .status_bank(status_bank),
    .param_addr(param_addr), .param_bank_addr(param_bank_addr), .param_stride(param_stride),
    .param_width(param_width), .param_height(param_height),
    .dma_enable(dma_enable), .dma_busy(dma_busy), .dma_addr(dma_addr), .dma_count(dma_count)
  );

  always #5 aclk = ~aclk;

  // Reader: logs each command, raises busy for `hold` cycles after enable.
  always @(negedge aclk) begin
    if (dma_enable === 1'b1) begin
      if (n_issue < 256) begin
        log_addr[n_issue]  = dma_addr;
        log_count[n_issue] = dma_count;
      end
      n_issue++;
      if (prev_en) dbl++;
      remain = hold;
    end else if (remain > 0) begin
      remain--;
    end
    prev_en = (dma_enable === 1'b1);
    if (ctl_frame_done === 1'b1) n_done++;
    dma_busy = ext_busy || (remain > 0);
  end

  task automatic step();
    @(negedge aclk);
    #1;
  endtask

  task automatic wait_issues(input int target, input int budget, input string name);
    int k = 0;
    while (n_issue < target && k < budget) begin
      step();
      k++;
    end
    total++;
    if (n_issue < target) begin
      bad++;
      $display("FAIL %s_wait: issues=%0d required=%0d", name, n_issue, target);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (ctl_busy !== 1'b0 && k < budget) begin
      step();
      k++;
    end
    total++;
    if (ctl_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: ctl_busy=%b required=0", name, ctl_busy);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) step();
    total++; if (ctl_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b exp 0", ctl_busy); end
    total++; if (dma_enable !== 1'b0) begin bad++; $display("FAIL rst_en: got %b exp 0", dma_enable); end
    total++; if (ctl_frame_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b exp 0", ctl_frame_done); end
    total++; if (status_frame_count !== 16'd0) begin bad++; $display("FAIL rst_fcnt: got %0d exp 0", status_frame_count); end
    total++; if (dma_addr !== 32'd0 || dma_count !== 30'd0) begin bad++; $display("FAIL rst_cmd: got %h/%h exp 0/0", dma_addr, dma_count); end
    total++; if (status_line !== 12'd0 || status_bank !== 1'b0) begin bad++; $display("FAIL rst_status: got %0d/%b exp 0/0", status_line, status_bank); end
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_oneshot();
    int b = n_issue;
    int d = n_done;
    logic [AW-1:0] ea [3];
    ea[0] = 32'h1000; ea[1] = 32'h1400; ea[2] = 32'h1800;
    hold = 20;
    param_addr = 32'h1000; param_bank_addr = 32'h1000; param_stride = 32'h400;
    param_width = 30'd16; param_height = 12'd3; ctl_oneshot = 1'b1;
    ctl_enable = 1'b1;
    step();
    total++; if (dma_enable !== 1'b1 || ctl_busy !== 1'b1) begin bad++; $display("FAIL os_start: en=%b busy=%b exp 1/1", dma_enable, ctl_busy); end
    total++; if (dma_addr !== 32'h1000 || dma_count !== 30'd16) begin bad++; $display("FAIL os_cmd0: got %h/%0d exp 1000/16", dma_addr, dma_count); end
    ctl_enable = 1'b0;
    wait_idle(300, "os");
    total++; if (n_issue - b !== 3) begin bad++; $display("FAIL os_issues: got %0d exp 3", n_issue - b); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (log_addr[b+i] !== ea[i] || log_count[b+i] !== 30'd16) begin
        bad++; $display("FAIL os_line%0d: got %h/%0d exp %h/16", i, log_addr[b+i], log_count[b+i], ea[i]);
      end
    end
    total++; if (n_done - d !== 1) begin bad++; $display("FAIL os_done: got %0d exp 1", n_done - d); end
    total++; if (status_frame_count !== 16'd1) begin bad++; $display("FAIL os_fcnt: got %0d exp 1", status_frame_count); end
    total++; if (status_bank !== BANK) begin bad++; $display("FAIL os_bank: got %b exp %b", status_bank, BANK); end
  endtask

  task automatic test_negative_stride();
    int b = n_issue;
    logic [AW-1:0] ea [3];
    ea[0] = 32'h2000; ea[1] = 32'h1F00; ea[2] = 32'h1E00;
    hold = 3;
    param_addr = 32'h2000; param_bank_addr = 32'h2000; param_stride = 32'hFFFF_FF00;
    param_width = 30'd4; param_height = 12'd3; ctl_oneshot = 1'b1;
    ctl_enable = 1'b1;
    step();
    ctl_enable = 1'b0;
    wait_idle(200, "neg");
    total++; if (n_issue - b !== 3) begin bad++; $display("FAIL neg_issues: got %0d exp 3", n_issue - b); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (log_addr[b+i] !== ea[i]) begin
        bad++; $display("FAIL neg_line%0d: got %h exp %h", i, log_addr[b+i], ea[i]);
      end
    end
    total++; if (status_frame_count !== 16'd2) begin bad++; $display("FAIL neg_fcnt: got %0d exp 2", status_frame_count); end
  endtask

  task automatic test_zero_size();
    int b = n_issue;
    int d = n_done;
    param_width = 30'd16; param_height = 12'd0; ctl_oneshot = 1'b1;
    ctl_enable = 1'b1;
    step();
    ctl_enable = 1'b0;
    repeat (6) step();
    total++; if (n_issue - b !== 0) begin bad++; $display("FAIL zh_issues: got %0d exp 0", n_issue - b); end
    total++; if (n_done - d !== 1) begin bad++; $display("FAIL zh_done: got %0d exp 1", n_done - d); end
    total++; if (status_frame_count !== 16'd3 || ctl_busy !== 1'b0) begin bad++; $display("FAIL zh_fcnt: got %0d/%b exp 3/0", status_frame_count, ctl_busy); end
    param_width = 30'd0; param_height = 12'd2;
    ctl_enable = 1'b1;
    step();
    ctl_enable = 1'b0;
    repeat (6) step();
    total++; if (n_issue - b !== 0 || n_done - d !== 2) begin bad++; $display("FAIL zw_counts: got %0d/%0d exp 0/2", n_issue - b, n_done - d); end
    total++; if (status_frame_count !== 16'd4) begin bad++; $display("FAIL zw_fcnt: got %0d exp 4", status_frame_count); end
  endtask

  task automatic test_busy_block();
    int b = n_issue;
    param_width = 30'd4; param_height = 12'd1;
    ext_busy = 1'b1;
    step();
    ctl_enable = 1'b1;
    repeat (5) step();
    total++; if (ctl_busy !== 1'b0 || n_issue - b !== 0) begin bad++; $display("FAIL blk: busy=%b issues=%0d exp 0/0", ctl_busy, n_issue - b); end
    ctl_enable = 1'b0;
    ext_busy = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_shadow();
    int b = n_issue;
    int d = n_done;
    logic [CW-1:0] ec [4];
    ec[0] = 30'd16; ec[1] = 30'd16; ec[2] = 30'd8; ec[3] = 30'd8;
    hold = 5;
    param_addr = 32'h100; param_bank_addr = 32'h100; param_stride = 32'h40;
    param_width = 30'd16; param_height = 12'd2; ctl_oneshot = 1'b0;
    ctl_enable = 1'b1;
    wait_issues(b + 1, 50, "sh0");
    param_width = 30'd8;
    wait_issues(b + 3, 200, "sh2");
    ctl_enable = 1'b0;
    wait_idle(200, "sh");
    total++; if (n_issue - b !== 4) begin bad++; $display("FAIL sh_issues: got %0d exp 4", n_issue - b); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (log_count[b+i] !== ec[i]) begin
        bad++; $display("FAIL sh_count%0d: got %0d exp %0d", i, log_count[b+i], ec[i]);
      end
    end
    total++; if (log_addr[b+3] !== 32'h140) begin bad++; $display("FAIL sh_addr3: got %h exp 140", log_addr[b+3]); end
    total++; if (n_done - d !== 2 || status_frame_count !== 16'd6) begin bad++; $display("FAIL sh_done: got %0d/%0d exp 2/6", n_done - d, status_frame_count); end
  endtask

  task automatic test_continuous_bank();
    int b = n_issue;
    int d = n_done;
    logic [AW-1:0] ea [6];
    ea[0] = 32'h0; ea[1] = 32'h100;
    ea[2] = BANK ? 32'h8000 : 32'h0; ea[3] = BANK ? 32'h8100 : 32'h100;
    ea[4] = 32'h0; ea[5] = 32'h100;
    hold = 4;
    param_addr = 32'h0; param_bank_addr = 32'h8000; param_stride = 32'h100;
    param_width = 30'd4; param_height = 12'd2; ctl_oneshot = 1'b0;
    total++; if (status_bank !== 1'b0) begin bad++; $display("FAIL cb_bank0: got %b exp 0", status_bank); end
    ctl_enable = 1'b1;
    wait_issues(b + 5, 400, "cb");
    ctl_enable = 1'b0;
    wait_idle(300, "cb");
    total++; if (n_issue - b !== 6) begin bad++; $display("FAIL cb_issues: got %0d exp 6", n_issue - b); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (log_addr[b+i] !== ea[i]) begin
        bad++; $display("FAIL cb_line%0d: got %h exp %h", i, log_addr[b+i], ea[i]);
      end
    end
    total++; if (n_done - d !== 3 || status_frame_count !== 16'd9) begin bad++; $display("FAIL cb_done: got %0d/%0d exp 3/9", n_done - d, status_frame_count); end
    total++; if (status_bank !== BANK) begin bad++; $display("FAIL cb_bank: got %b exp %b", status_bank, BANK); end
  endtask

  task automatic test_reset_midline();
    int b = n_issue;
    hold = 10;
    param_addr = 32'h3000; param_bank_addr = 32'h3000; param_stride = 32'h10;
    param_width = 30'd2; param_height = 12'd3; ctl_oneshot = 1'b1;
    ctl_enable = 1'b1;
    wait_issues(b + 2, 100, "rm");
    total++; if (status_line !== 12'd1) begin bad++; $display("FAIL rm_line1: got %0d exp 1", status_line); end
    ctl_enable = 1'b0;
    repeat (3) step();
    aresetn = 1'b0;
    step();
    total++; if (ctl_busy !== 1'b0 || dma_enable !== 1'b0 || ctl_frame_done !== 1'b0) begin bad++; $display("FAIL rm_ctl: got %b%b%b exp 000", ctl_busy, dma_enable, ctl_frame_done); end
    total++; if (status_line !== 12'd0 || status_frame_count !== 16'd0 || status_bank !== 1'b0) begin bad++; $display("FAIL rm_status: got %0d/%0d/%b exp 0/0/0", status_line, status_frame_count, status_bank); end
    total++; if (dma_addr !== 32'd0 || dma_count !== 30'd0) begin bad++; $display("FAIL rm_cmd: got %h/%0d exp 0/0", dma_addr, dma_count); end
    aresetn = 1'b1;
    repeat (15) step();
    ctl_enable = 1'b1;
    step();
    total++; if (dma_enable !== 1'b1 || status_line !== 12'd0 || dma_addr !== 32'h3000) begin bad++; $display("FAIL rm_restart: en=%b line=%0d addr=%h exp 1/0/3000", dma_enable, status_line, dma_addr); end
    ctl_enable = 1'b0;
    wait_idle(300, "rm");
    total++; if (status_frame_count !== 16'd1) begin bad++; $display("FAIL rm_fcnt: got %0d exp 1", status_frame_count); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_negative_stride();
    test_zero_size();
    test_busy_block();
    test_shadow();
    test_continuous_bank();
    test_reset_midline();
    total++; if (dbl !== 0) begin bad++; $display("FAIL single_pulse: doubles=%0d exp 0", dbl); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jelly_axi4_dma_reader_sequencer.md
# jelly_axi4_dma_reader_sequencer

Line/frame sequencer for the AXI4 DMA reader: splits a 2-D frame (width × height, arbitrary byte stride) into one DMA reader command per line. It drives the reader's `enable`, `param_addr` and `param_count` and watches its `busy`. It sits between the register/control logic and a single DMA reader instance. Runs one frame on request, or frames back to back while enabled.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: byte address width; must match the reader's `AXI4_ADDR_WIDTH`.
- `COUNT_WIDTH`, 30: words-per-line width; must match the reader's `COUNT_WIDTH`.
- `HEIGHT_WIDTH`, 12: line counter width.
- `FRAME_COUNTER_WIDTH`, 16: frame counter width.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: reset, synchronous, active-low.
- `ctl_enable` in 1: level; run frames while high.
- `ctl_oneshot` in 1: level; when high, stop after the current frame.
- `ctl_busy` out 1: high when not IDLE.
- `ctl_frame_done` out 1: one-cycle pulse at frame completion.
- `status_line` out HEIGHT_WIDTH: index of the current line.
- `status_frame_count` out FRAME_COUNTER_WIDTH: number of completed frames.
- `status_bank` out 1: bank of the current or next frame.
- `param_addr` in ADDR_WIDTH: bank-0 frame base address (bytes).
- `param_bank_addr` in ADDR_WIDTH: bank-1 frame base address.
- `param_stride` in ADDR_WIDTH: line stride in bytes, two's complement.
- `param_width` in COUNT_WIDTH: words per line.
- `param_height` in HEIGHT_WIDTH: lines per frame.
- `dma_enable` out 1: start pulse to the reader.
- `dma_busy` in 1: reader busy.
- `dma_addr` out ADDR_WIDTH: line start address.
- `dma_count` out COUNT_WIDTH: line word count.

## Operation
- **Param shadowing:** all `param_*` inputs are latched into shadow registers at frame start. Changes mid-frame have no effect.
- **States:**
  - IDLE: if `ctl_enable`=1 and `dma_busy`=0, latch params and start a frame (see *Frame start*). Otherwise stay.
  - ISSUE: `dma_enable`=1 for exactly this cycle. Always go to WAIT_BUSY.
  - WAIT_BUSY: wait for `dma_busy`=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for `dma_busy`=0, then go to NEXT.
  - NEXT, not the last line: `dma_addr` += stride (mod 2^ADDR_WIDTH); `status_line`++; go to ISSUE.
  - NEXT, last line: pulse `ctl_frame_done`; `status_frame_count`++ (wraps); toggle bank. Then:
    - if `ctl_enable`=1 and `ctl_oneshot`=0: start a new frame (relatch params; line 0);
    - otherwise go to IDLE.
- **Frame start:**
  - `status_line`=0.
  - `dma_addr` = `param_bank_addr` if the bank is 1, else `param_addr`.
  - `dma_count` = `param_width`.
  - Go to ISSUE.
- **Last line:** `status_line` == height−1.
- **Zero-size frame:** if `param_width`=0 or `param_height`=0 at frame start, no ISSUE occurs. Go straight to frame completion (`ctl_frame_done` pulse, counter increment, then the NEXT last-line rules).
- **Deasserting `ctl_enable`:** never aborts a frame in progress. It only prevents the next frame.
- **Reset:**
  - All state returns to IDLE immediately, including mid-frame.
  - Outputs: `dma_enable`=0, `ctl_busy`=0, `ctl_frame_done`=0, `status_line`=0, `status_frame_count`=0, `status_bank`=0, `dma_addr`=0, `dma_count`=0.

## Timing
- All outputs are registered.
- **Start:** `ctl_enable` sampled high in IDLE at edge N. At N+1, state is ISSUE, `dma_enable`=1, `dma_addr`/`dma_count` valid, `ctl_busy`=1.
- **Command hold:** `dma_addr`/`dma_count` are stable from the ISSUE cycle until the next NEXT state.
- **Single pulse:** `dma_enable` is never high for two consecutive cycles.
- **Line gap:** `dma_busy` sampled low in WAIT_DONE at edge M → NEXT at M+1 → ISSUE at M+2. The minimum line gap is therefore 2 idle cycles after `busy` falls.
- **Frame done:** the `ctl_frame_done` pulse is coincident with the last-line NEXT cycle. `status_frame_count` and `status_bank` update on that same edge.
- **Reader already busy:** `dma_busy` already high in IDLE blocks the start.
- **Unexpected busy drop:** `dma_busy` falling while in WAIT_BUSY is not possible with the reader, since its `busy` is registered one cycle after `enable`. The block must stay in WAIT_BUSY until `busy` is seen high; there is no timeout.

## Configuration
- **`JELLY_AXI4_DMA_READER_SEQUENCER_BANK_EN` defined:** the bank toggles at each frame completion. Frames alternate between `param_addr` (bank 0) and `param_bank_addr` (bank 1).
- **Not defined:** `param_bank_addr` is ignored and `status_bank` is tied to 0. Every frame uses `param_addr`. The bank register and its mux are removed.

## Test plan
- **Oneshot frame:** addr=0x1000, stride=0x400, width=16, height=3, oneshot=1, enable held; reader model holds busy for 20 cycles. Expect 3 `dma_enable` pulses with addr 0x1000/0x1400/0x1800, count 16; one `ctl_frame_done`; frame_count=1; return to IDLE.
- **Continuous with banks (BANK_EN):** addr=0x0, bank_addr=0x8000, height=2, oneshot=0. Expect frame starts at 0x0, 0x8000, 0x0. Deassert enable mid-frame 3: frame 3 completes, then IDLE; frame_count=3.
- **Negative stride:** addr=0x2000, stride=0xFFFFFF00, height=3. Expect addresses 0x2000/0x1F00/0x1E00.
- **Zero height:** height=0, oneshot=1. Expect no `dma_enable`, one `ctl_frame_done`, frame_count=1.
- **Reset mid-line:** assert `aresetn`=0 during WAIT_DONE of line 1. Next cycle expect IDLE with all outputs at their reset values. After release, a restart begins from line 0.
- **Param shadowing:** change `param_width` from 16 to 8 during line 0. Expect all lines of the current frame with count 16; the next frame uses 8.
